// File: rtl/axis_pulse_sequencer_pkg.sv
// Shared types and default widths for the pulse sequencer.
// Optional WAIT_TRG timeout: AXIS_PULSE_SEQUENCER_TIMEOUT_EN.
package axis_pulse_sequencer_pkg;

  localparam int DEF_CNTR_W = 64;
  localparam int DEF_REP_W  = 16;
  localparam int DEF_GAP_W  = 32;
  localparam int DEF_TMO_W  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_WAIT,
    S_SEND,
    S_GAP
  } state_e;

endpackage

// File: rtl/axis_pulse_sequencer_if.sv
// AXI4-Stream result bus for the pulse sequencer.
// master drives data/valid/last, slave drives ready.
interface axis_pulse_sequencer_if
  import axis_pulse_sequencer_pkg::*;
#(
  parameter int W = DEF_CNTR_W
) ();

  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/axis_pulse_sequencer_out_reg.sv
// Single-entry AXIS output register: capture once,
// hold stable until the downstream handshake.
module axis_pulse_sequencer_out_reg
  import axis_pulse_sequencer_pkg::*;
#(
  parameter int W = DEF_CNTR_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         cap_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  output logic         hs_o,
  axis_pulse_sequencer_if.master m_axis
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;

  assign hs_o = valid_q & m_axis.tready;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (clr_i) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (cap_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      last_d  = last_i;
    end else if (hs_o) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;

endmodule

// File: rtl/axis_pulse_sequencer.sv
// Burst sequencer: load cfg, arm N measurements with a gap, stream results.
// Optional WAIT_TRG timeout: AXIS_PULSE_SEQUENCER_TIMEOUT_EN.
module axis_pulse_sequencer
  import axis_pulse_sequencer_pkg::*;
#(
  parameter int CNTR_WIDTH = DEF_CNTR_W,
  parameter int REP_WIDTH  = DEF_REP_W,
  parameter int GAP_WIDTH  = DEF_GAP_W
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
  , parameter int TMO_WIDTH = DEF_TMO_W
`endif
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [REP_WIDTH-1:0]  cfg_repeat,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [CNTR_WIDTH-1:0] cfg_meas,
  output logic                  meas_run_flag,
  output logic                  meas_cfg_flag,
  output logic [CNTR_WIDTH-1:0] meas_cfg_data,
  input  logic                  meas_trg_flag,
  input  logic [CNTR_WIDTH-1:0] meas_sts_data,
  axis_pulse_sequencer_if.master m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [REP_WIDTH-1:0]  sts_count
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
  , input  logic [TMO_WIDTH-1:0] cfg_timeout
  , output logic                 timeout_flag
`endif
);

  state_e state_q, state_d;

  logic [REP_WIDTH-1:0]  rem_q, rem_d;
  logic [REP_WIDTH-1:0]  cnt_q, cnt_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic [GAP_WIDTH-1:0]  gcfg_q, gcfg_d;
  logic [CNTR_WIDTH-1:0] cfg_q, cfg_d;
  logic                  done_q, done_d;
  logic                  cap;
  logic                  hs;

`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
  logic [TMO_WIDTH-1:0] tcfg_q, tcfg_d;
  logic                 tflag_q, tflag_d;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gcfg_d  = gcfg_q;
    cfg_d   = cfg_q;
    done_d  = 1'b0;
    cap     = 1'b0;
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
    tmo_d   = tmo_q;
    tcfg_d  = tcfg_q;
    tflag_d = tflag_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            // a repeat of 0 still runs one measurement
            rem_d   = cfg_repeat
                    | REP_WIDTH'(cfg_repeat == '0);
            gcfg_d  = cfg_gap;
            cfg_d   = cfg_meas;
            cnt_d   = '0;
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
            tcfg_d  = cfg_timeout;
            tflag_d = 1'b0;
`endif
          end
        end
        S_LOAD: state_d = S_ARM;
        S_ARM: begin
          state_d = S_WAIT;
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
        S_WAIT: begin
          if (meas_trg_flag) begin
            cap     = 1'b1;
            state_d = S_SEND;
          end
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
          else if (tcfg_q != '0 &&
                   tmo_q + 1'b1 == tcfg_q) begin
            state_d = S_IDLE;
            tflag_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
        S_SEND: begin
          if (hs) begin
            cnt_d = cnt_q + 1'b1;
            rem_d = rem_q - 1'b1;
            if (rem_q == REP_WIDTH'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else if (gcfg_q == '0) begin
              state_d = S_ARM;
            end else begin
              gap_d   = gcfg_q;
              state_d = S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_q != '0) gap_d = gap_q - 1'b1;
          if (gap_q <= GAP_WIDTH'(1)) state_d = S_ARM;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      gcfg_q  <= '0;
      cfg_q   <= '0;
      done_q  <= 1'b0;
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
      tmo_q   <= '0;
      tcfg_q  <= '0;
      tflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gcfg_q  <= gcfg_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
      tmo_q   <= tmo_d;
      tcfg_q  <= tcfg_d;
      tflag_q <= tflag_d;
`endif
    end
  end

  axis_pulse_sequencer_out_reg #(
    .W (CNTR_WIDTH)
  ) u_out (
    .clk_i  (aclk),
    .rst_i  (areset),
    .clr_i  (abort),
    .cap_i  (cap),
    .data_i (meas_sts_data),
    .last_i (rem_q == REP_WIDTH'(1)),
    .hs_o   (hs),
    .m_axis (m_axis)
  );

  assign meas_run_flag = (state_q == S_ARM)
                       | (state_q == S_WAIT);
  assign meas_cfg_flag = (state_q == S_LOAD);
  assign meas_cfg_data = cfg_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign sts_count     = cnt_q;
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
  assign timeout_flag  = tflag_q;
`endif

endmodule

// File: tb/tb_axis_pulse_sequencer.sv
// Directed bench for axis_pulse_sequencer with a result scoreboard.
// Timeout steps build only with AXIS_PULSE_SEQUENCER_TIMEOUT_EN.
module tb_axis_pulse_sequencer;

  localparam int CW = 64;
  localparam int RW = 16;
  localparam int GW = 32;

  logic          aclk   = 1'b0;
  logic          areset = 1'b1;
  logic          start  = 1'b0;
  logic          abort  = 1'b0;
  logic          trg    = 1'b0;
  logic [RW-1:0] rep    = '0;
  logic [GW-1:0] gap    = '0;
  logic [CW-1:0] cfgm   = '0;
  logic [CW-1:0] sts    = '0;
  logic          run, cfgf, busy, done;
  logic [CW-1:0] cfgd;
  logic [RW-1:0] cnt;
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
  logic [31:0]   tmo = '0;
  logic          tflag;
`endif

  axis_pulse_sequencer_if #(.W(CW)) axis ();

  axis_pulse_sequencer dut (
    .aclk          (aclk),
    .areset        (areset),
    .start         (start),
    .abort         (abort),
    .cfg_repeat    (rep),
    .cfg_gap       (gap),
    .cfg_meas      (cfgm),
    .meas_run_flag (run),
    .meas_cfg_flag (cfgf),
    .meas_cfg_data (cfgd),
    .meas_trg_flag (trg),
    .meas_sts_data (sts),
    .m_axis        (axis),
    .busy          (busy),
    .done          (done),
    .sts_count     (cnt)
`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
    , .cfg_timeout (tmo)
    , .timeout_flag(tflag)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [CW-1:0] d;
    logic          l;
  } exp_t;

  exp_t sbq[$];
  int   checks  = 0;
  int   errors  = 0;
  int   donecnt = 0;
  int   cfgcnt  = 0;

  task automatic chk(input string tag,
                     input logic [CW-1:0] obs,
                     input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_run(output int n);
    n = 0;
    while (run !== 1'b1 && n < 500) begin
      step();
      n++;
    end
    if (run !== 1'b1) chk("wait_run", run, 1);
  endtask

  task automatic go(input logic [RW-1:0] r,
                    input logic [GW-1:0] g,
                    input logic [CW-1:0] m);
    rep   = r;
    gap   = g;
    cfgm  = m;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_strobe", cfgf, 1);
    chk("load_data", cfgd, m);
    chk("load_busy", busy, 1);
  endtask

  task automatic meas_one(input logic [CW-1:0] dat,
                          input logic lst,
                          output int n);
    wait_run(n);
    repeat (10) step();
    chk("run_in_wait", run, 1);
    trg = 1'b1;
    sts = dat;
    sbq.push_back('{d: dat, l: lst});
    step();
    trg = 1'b0;
    sts = {$urandom, $urandom};
    chk("tvalid_lat", axis.tvalid, 1);
    chk("run_drop", run, 0);
    chk("cap_last", axis.tlast, lst);
    chk("cap_data", axis.tdata, dat);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_cfgf"}, cfgf, 0);
    chk({tag, "_cfgd"}, cfgd, 0);
    chk({tag, "_tvalid"}, axis.tvalid, 0);
    chk({tag, "_tlast"}, axis.tlast, 0);
    chk({tag, "_tdata"}, axis.tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, cnt, 0);
  endtask

  exp_t e;
  always @(negedge aclk) begin
    if (!areset) begin
      if (done) donecnt++;
      if (cfgf) cfgcnt++;
      if (axis.tvalid && axis.tready) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", axis.tvalid, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_data", axis.tdata, e.d);
          chk("sb_last", axis.tlast, e.l);
        end
      end
    end
  end

  initial begin
    int n;
    int dc;
    bit stable;
    logic [CW-1:0] a;
    logic [CW-1:0] m;
    axis.tready = 1'b1;

    repeat (3) step();
    chk_zero("reset");
    areset = 1'b0;
    step();

    // basic burst: 3 results, gap 4
    m = {$urandom, $urandom};
    go(3, 4, m);
    meas_one(64'h1111_0000_0000_0001, 0, n);
    chk("first_arm", n, 1);
    meas_one(64'h2222_0000_0000_0002, 0, n);
    chk("gap4_cycles", n, 5);
    meas_one(64'h3333_0000_0000_0003, 1, n);
    chk("gap4_cycles2", n, 5);
    step();
    chk("b_done", done, 1);
    chk("b_busy", busy, 0);
    chk("b_cnt", cnt, 3);
    chk("b_tvalid", axis.tvalid, 0);
    step();
    chk("b_done_pulse", done, 0);
    chk("b_donecnt", donecnt, 1);
    chk("b_cfgcnt", cfgcnt, 1);
    chk("b_sb_empty", sbq.size(), 0);

    // backpressure, gap 0
    axis.tready = 1'b0;
    go(2, 0, {$urandom, $urandom});
    a = {$urandom, $urandom};
    meas_one(a, 0, n);
    stable = 1'b1;
    repeat (20) begin
      step();
      if (axis.tvalid !== 1'b1 || axis.tdata !== a ||
          axis.tlast !== 1'b0 || run !== 1'b0 ||
          cnt !== '0)
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    axis.tready = 1'b1;
    step();
    chk("bp_rearm_next", run, 1);
    chk("bp_cnt", cnt, 1);
    chk("bp_tvalid", axis.tvalid, 0);
    meas_one({$urandom, $urandom}, 1, n);
    chk("bp_arm_wait", n, 0);
    step();
    chk("bp_done", done, 1);
    chk("bp_cnt2", cnt, 2);

    // repeat 0 behaves as 1
    go(0, 0, {$urandom, $urandom});
    meas_one({$urandom, $urandom}, 1, n);
    step();
    chk("r0_done", done, 1);
    chk("r0_cnt", cnt, 1);
    chk("r0_busy", busy, 0);

    // abort in WAIT_TRG of 2nd of 4
    go(4, 2, {$urandom, $urandom});
    meas_one({$urandom, $urandom}, 0, n);
    step();
    chk("ab_cnt1", cnt, 1);
    wait_run(n);
    repeat (3) step();
    dc = donecnt;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_run", run, 0);
    chk("ab_busy", busy, 0);
    chk("ab_cnt", cnt, 1);
    chk("ab_tvalid", axis.tvalid, 0);
    trg = 1'b1;
    sts = {$urandom, $urandom};
    step();
    trg = 1'b0;
    step();
    chk("ab_late_trg", axis.tvalid, 0);
    chk("ab_no_done", donecnt, dc);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("ab_start_ign", busy, 0);
    go(1, 0, {$urandom, $urandom});
    meas_one({$urandom, $urandom}, 1, n);
    step();
    chk("ab_restart_done", done, 1);

    // spurious trigger, start while busy
    trg = 1'b1;
    step();
    trg = 1'b0;
    step();
    chk("sp_idle_trg", axis.tvalid, 0);
    m = {$urandom, $urandom};
    go(2, 3, m);
    meas_one({$urandom, $urandom}, 0, n);
    step();
    trg   = 1'b1;
    start = 1'b1;
    cfgm  = ~m;
    step();
    trg   = 1'b0;
    start = 1'b0;
    chk("sp_gap_trg", axis.tvalid, 0);
    chk("sp_no_reload", cfgf, 0);
    chk("sp_busy", busy, 1);
    chk("sp_cfgd", cfgd, m);
    axis.tready = 1'b0;
    meas_one({$urandom, $urandom}, 1, n);
    chk("sp_pending", sbq.size(), 1);
    areset = 1'b1;
    step();
    chk_zero("midsend_rst");
    sbq.delete();
    areset = 1'b0;
    axis.tready = 1'b1;
    step();

`ifdef AXIS_PULSE_SEQUENCER_TIMEOUT_EN
    tmo = 50;
    dc  = donecnt;
    go(1, 0, {$urandom, $urandom});
    wait_run(n);
    n = 0;
    while (run === 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("tmo_cycles", n, 51);
    chk("tmo_flag", tflag, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_tvalid", axis.tvalid, 0);
    chk("tmo_no_done", donecnt, dc);
    go(1, 0, {$urandom, $urandom});
    chk("tmo_clr", tflag, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
`endif

    chk("end_sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
